// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Owns the 64-bit program counter and sequences instruction
//               fetch. Each fetch holds a request to instruction memory at
//               the current PC until it is accepted. The PC then advances
//               by 4, or moves to a branch target. Delivered words go to
//               decode together with their PC.
// Ports       : clk_i            - clock, rising edge
//               reset_i          - synchronous active-high reset
//               stall_i          - decode back-pressure, blocks new fetches
//               branch_taken_i   - redirect request, sampled every cycle
//               branch_target_i  - redirect address (low two bits cleared)
//               imem_req_o       - fetch request (high only while fetching)
//               imem_addr_o      - fetch address, always equal to pc
//               imem_ready_i     - memory completes the transaction this cycle
//               imem_rdata_i     - instruction word from memory
//               instr_valid_o    - one-cycle pulse, instr/instr_pc are valid
//               instr_o          - delivered instruction word
//               instr_pc_o       - PC of the delivered instruction
//               pc_o             - current PC register
//               align_err_o      - one-cycle pulse on a misaligned target
//               fetch_err_o      - sticky fetch timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [63:0] branch_target_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  output logic [63:0] pc_o,
  output logic        align_err_o,
  output logic        fetch_err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] tgt_q, tgt_d;
  logic        squash_q, squash_d;
  logic [7:0]  wait_q, wait_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;
  logic        align_err_q, align_err_d;

  logic        w_complete;
  logic [63:0] w_tgt_aligned;
  logic [7:0]  w_wait_inc;
  logic        w_timeout;

  assign w_complete    = (state_q == S_FETCH) && imem_ready_i;
  assign w_tgt_aligned = {branch_target_i[63:2], 2'b00};
  assign w_wait_inc    = wait_q + 8'd1;
  // The cycle that would bring the counter to TIMEOUT without ready is the
  // last cycle the request is allowed to stay outstanding.
  assign w_timeout     = (state_q == S_FETCH) && !imem_ready_i &&
                         (w_wait_inc == C_TIMEOUT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = stall_i ? S_STALL : S_FETCH;
      S_FETCH: begin
        if (w_complete) begin
          state_d = stall_i ? S_STALL : S_FETCH;
        end else if (w_timeout) begin
          state_d = S_ERROR;
        end
      end
      S_STALL: begin
        if (!stall_i) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_ERROR;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req_o  = (state_q == S_FETCH);
    fetch_err_o = (state_q == S_ERROR);
  end

  // --------------------------------------------------------------------------
  // PC, redirect and delivery datapath
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    squash_d      = squash_q;
    wait_d        = wait_q;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    align_err_d   = branch_taken_i && (branch_target_i[1:0] != 2'b00);

    if (w_complete) begin
      // A word fetched while a redirect is pending, or in the same cycle as
      // one, belongs to the wrong path and is dropped.
      if (!squash_q && !branch_taken_i) begin
        instr_valid_d = 1'b1;
        instr_d       = imem_rdata_i;
        instr_pc_d    = pc_q;
      end
      if (branch_taken_i) begin
        pc_d = w_tgt_aligned;
      end else if (squash_q) begin
        pc_d = tgt_q;
      end else begin
        pc_d = pc_q + 64'd4;
      end
      squash_d = 1'b0;
      wait_d   = 8'd0;
    end else if (state_q == S_FETCH) begin
      // Keep pc (and therefore imem_addr) stable while the request is open;
      // the redirect is applied when the transaction completes.
      if (branch_taken_i) begin
        tgt_d    = w_tgt_aligned;
        squash_d = 1'b1;
      end
      wait_d = w_wait_inc;
    end else begin
      if (branch_taken_i) begin
        pc_d = w_tgt_aligned;
      end
      if (state_d == S_FETCH) begin
        wait_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q          <= RESET_PC;
      tgt_q         <= 64'd0;
      squash_q      <= 1'b0;
      wait_q        <= 8'd0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 64'd0;
      align_err_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      squash_q      <= squash_d;
      wait_q        <= wait_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      align_err_q   <= align_err_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign align_err_o   = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Self-checking bench for pc_fetch_sequencer. Two instances
//               (default parameters, and a wrap-around reset PC with a short
//               timeout) share one stimulus stream and are each compared
//               every cycle against a behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam logic [63:0] C_RPC0 = 64'h0;
  localparam logic [63:0] C_RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          C_TO0  = 255;
  localparam int          C_TO1  = 5;

  logic        clk = 1'b0;
  logic        reset, stall, br, rdy;
  logic [63:0] tgt;
  logic [31:0] rdata;

  logic        o_req [2];
  logic [63:0] o_addr[2];
  logic        o_val [2];
  logic [31:0] o_ins [2];
  logic [63:0] o_ipc [2];
  logic [63:0] o_pc  [2];
  logic        o_aln [2];
  logic        o_err [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state, one set per instance
  logic [63:0] m_pc   [2];
  logic        m_busy [2];   // a request is outstanding
  logic        m_err  [2];
  int          m_wait [2];
  logic        m_pend [2];   // redirect waiting for the open fetch to finish
  logic [63:0] m_ptgt [2];
  logic        m_val  [2];
  logic [31:0] m_ins  [2];
  logic [63:0] m_ipc  [2];
  logic        m_aln  [2];

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_PC(C_RPC0), .TIMEOUT(C_TO0)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_req_o(o_req[0]), .imem_addr_o(o_addr[0]),
    .imem_ready_i(rdy), .imem_rdata_i(rdata),
    .instr_valid_o(o_val[0]), .instr_o(o_ins[0]), .instr_pc_o(o_ipc[0]),
    .pc_o(o_pc[0]), .align_err_o(o_aln[0]), .fetch_err_o(o_err[0])
  );

  pc_fetch_sequencer #(.RESET_PC(C_RPC1), .TIMEOUT(C_TO1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_req_o(o_req[1]), .imem_addr_o(o_addr[1]),
    .imem_ready_i(rdy), .imem_rdata_i(rdata),
    .instr_valid_o(o_val[1]), .instr_o(o_ins[1]), .instr_pc_o(o_ipc[1]),
    .pc_o(o_pc[1]), .align_err_o(o_aln[1]), .fetch_err_o(o_err[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step(input int k);
    logic [63:0] rpc;
    int          to;
    logic        done;
    rpc = (k == 0) ? C_RPC0 : C_RPC1;
    to  = (k == 0) ? C_TO0 : C_TO1;
    if (reset) begin
      m_pc[k] = rpc; m_busy[k] = 1'b0; m_err[k] = 1'b0; m_wait[k] = 0;
      m_pend[k] = 1'b0; m_ptgt[k] = 64'd0; m_val[k] = 1'b0;
      m_ins[k] = 32'd0; m_ipc[k] = 64'd0; m_aln[k] = 1'b0;
      return;
    end
    done     = m_busy[k] && rdy;
    m_aln[k] = br && (tgt % 4 != 0);
    m_val[k] = 1'b0;
    if (done) begin
      if (!m_pend[k] && !br) begin
        m_val[k] = 1'b1; m_ins[k] = rdata; m_ipc[k] = m_pc[k];
      end
      if (br)             m_pc[k] = tgt - (tgt % 4);
      else if (m_pend[k]) m_pc[k] = m_ptgt[k];
      else                m_pc[k] = m_pc[k] + 64'd4;
      m_pend[k] = 1'b0;
      m_wait[k] = 0;
      m_busy[k] = !stall;
    end else if (m_busy[k]) begin
      if (br) begin
        m_pend[k] = 1'b1; m_ptgt[k] = tgt - (tgt % 4);
      end
      m_wait[k]++;
      if (m_wait[k] == to) begin
        m_busy[k] = 1'b0; m_err[k] = 1'b1;
      end
    end else begin
      if (br) m_pc[k] = tgt - (tgt % 4);
      if (!m_err[k]) begin
        m_busy[k] = !stall;
        m_wait[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.imem_req", k),    64'(o_req[k]), 64'(m_busy[k]));
      chk($sformatf("d%0d.imem_addr", k),   o_addr[k],     m_pc[k]);
      chk($sformatf("d%0d.pc", k),          o_pc[k],       m_pc[k]);
      chk($sformatf("d%0d.instr_valid", k), 64'(o_val[k]), 64'(m_val[k]));
      chk($sformatf("d%0d.instr", k),       64'(o_ins[k]), 64'(m_ins[k]));
      chk($sformatf("d%0d.instr_pc", k),    o_ipc[k],      m_ipc[k]);
      chk($sformatf("d%0d.align_err", k),   64'(o_aln[k]), 64'(m_aln[k]));
      chk($sformatf("d%0d.fetch_err", k),   64'(o_err[k]), 64'(m_err[k]));
    end
  endtask

  // One cycle: check the outputs of the previous edge, drive new inputs and
  // advance the model to what the next edge should produce.
  task automatic cyc(input logic i_rst, input logic i_st, input logic i_br,
                     input logic [63:0] i_tgt, input logic i_rdy);
    @(negedge clk);
    check_all();
    reset = i_rst; stall = i_st; br = i_br; tgt = i_tgt; rdy = i_rdy;
    rdata = $urandom;
    model_step(0);
    model_step(1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br = 1'b0; tgt = 64'd0; rdy = 1'b0; rdata = 32'd0;
    model_step(0);
    model_step(1);

    // Back-to-back fetches with memory always ready
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    // Fetch at 0x10 waits three cycles then completes
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("wait_then_pc14", o_pc[0], 64'h14);
    // Advance to 0x20, redirect to 0x100 while waiting there
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 64'h100, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("squash_pc100", o_pc[0], 64'h100);
    chk("squash_no_valid", 64'(o_val[0]), 64'd0);
    // Misaligned redirect while stalled
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 64'h203, 0);
    cyc(0, 1, 0, 0, 0);
    chk("stall_redirect_pc", o_pc[0], 64'h200);
    chk("stall_align_err", 64'(o_aln[0]), 64'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    // Reset during a wait; the late ready must be ignored
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_mid_wait_pc", o_pc[0], 64'h0);
    chk("reset_mid_wait_valid", 64'(o_val[0]), 64'd0);
    // Wrap-around PC and timeout on the second instance
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_pc_zero", o_pc[1], 64'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("timeout_fetch_err", 64'(o_err[1]), 64'd1);
    chk("timeout_no_req", 64'(o_req[1]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) t[63:12] = '0;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), t, ($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
